// File: rtl/arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter family.
package arb_pkg;

    localparam int unsigned N_MAX = 16;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Low bit of client idx's field in a flattened per-client bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Cyclic first-set picker: lowest request at or after i_ptr, wrapping N-1 -> 0.
module rr_pick_n
    import arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          i_req,
    input  logic [clog2(N)-1:0]   i_ptr,
    output logic [clog2(N)-1:0]   o_grant_c,
    output logic                  o_valid_c
);

    localparam int unsigned IW = clog2(N);
    localparam int unsigned OW = IW + 1;

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [OW-1:0]  w_off;
    logic [OW-1:0]  w_sum;

    // Rotate so i_ptr lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        w_dbl     = {i_req, i_req} >> i_ptr;
        w_rot     = w_dbl[N-1:0];
        w_off     = '0;
        o_valid_c = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off     = OW'(i);
                o_valid_c = 1'b1;
            end
        end
        w_sum = OW'(i_ptr) + w_off;
        if (w_sum >= OW'(N)) w_sum = w_sum - OW'(N);
        o_grant_c = w_sum[IW-1:0];
    end

endmodule

// File: rtl/arb_wrr_n.sv
// N-client weighted round-robin arbiter with a registered memory request slot
// and in-order routing of read responses back to the issuing client.
module arb_wrr_n
    import arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned AW    = 10,
    parameter int unsigned TW    = 4,
    parameter int unsigned WW    = 4,
    parameter int unsigned OUTST = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    client_req,
    input  logic [N-1:0]    client_read,
    input  logic [N*AW-1:0] client_addr,
    input  logic [N*W-1:0]  client_wdata,
    input  logic [N*TW-1:0] client_tag,
    input  logic [N*WW-1:0] client_weight,
    output logic [N-1:0]    client_bsy,
    output logic            mem_req,
    input  logic            mem_bsy,
    output logic            mem_read,
    output logic [AW-1:0]   mem_addr,
    output logic [W-1:0]    mem_wdata,
    output logic [TW-1:0]   mem_tag,
    input  logic            mem_rvalid,
    input  logic [W-1:0]    mem_rdata,
    output logic [N-1:0]    client_rvalid,
    output logic [W-1:0]    client_rdata,
    output logic            err_unexp_rsp
);

    localparam int unsigned IW = clog2(N);
    localparam int unsigned PW = clog2(OUTST);
    localparam int unsigned CW = PW + 1;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(N - 1)) ? '0 : p + IW'(1);
    endfunction

    logic [AW-1:0] w_addr  [N];
    logic [W-1:0]  w_wdata [N];
    logic [TW-1:0] w_tag   [N];
    logic [WW-1:0] w_wt    [N];

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign w_addr[g]  = client_addr[slice_lo(g, AW) +: AW];
        assign w_wdata[g] = client_wdata[slice_lo(g, W) +: W];
        assign w_tag[g]   = client_tag[slice_lo(g, TW) +: TW];
        assign w_wt[g]    = (client_weight[slice_lo(g, WW) +: WW] == '0)
                          ? WW'(1) : client_weight[slice_lo(g, WW) +: WW];
    end

    logic            r_run;
    logic            r_mem_req;
    logic            r_mem_read;
    logic [AW-1:0]   r_mem_addr;
    logic [W-1:0]    r_mem_wdata;
    logic [TW-1:0]   r_mem_tag;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [WW-1:0]   r_credit;
    logic [IW-1:0]   r_fifo [OUTST];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_client_rvalid;
    logic [W-1:0]    r_client_rdata;
    logic            r_err;

    logic            w_load;
    logic            w_rd_full;
    logic [N-1:0]    w_elig;
    logic            w_keep;
    logic            w_lost;
    logic [IW-1:0]   w_pick;
    logic            w_pick_v;
    logic [IW-1:0]   w_grant;
    logic            w_gv;
    logic            w_xfer;
    logic [WW-1:0]   w_credit_nxt;
    logic            w_push;
    logic            w_pop;

    rr_pick_n #(.N(N)) u_pick (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_grant_c (w_pick),
        .o_valid_c (w_pick_v)
    );

    // Grant decision; r_run keeps every client busy until the first edge after reset.
    always_comb begin
        w_load       = ~r_mem_req | ~mem_bsy;
        w_rd_full    = (r_cnt == CW'(OUTST));
        w_elig       = client_req & ~(client_read & {N{w_rd_full}});
        w_keep       = (r_credit != '0) & w_elig[r_owner];
        w_lost       = r_run & w_load & (r_credit != '0) & ~w_elig[r_owner];
        w_grant      = w_keep ? r_owner : w_pick;
        w_gv         = w_keep | w_pick_v;
        w_xfer       = r_run & w_load & w_gv;
        w_credit_nxt = w_keep ? r_credit - WW'(1) : w_wt[w_grant] - WW'(1);
        w_push       = w_xfer & client_read[w_grant];
        w_pop        = mem_rvalid & (r_cnt != '0);
        client_bsy   = '1;
        if (w_xfer) client_bsy[w_grant] = 1'b0;
    end

    // Request slot and burst ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_tag   <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_credit    <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_load) r_mem_req <= w_xfer;
            if (w_xfer) begin
                r_mem_read  <= client_read[w_grant];
                r_mem_addr  <= w_addr[w_grant];
                r_mem_wdata <= w_wdata[w_grant];
                r_mem_tag   <= w_tag[w_grant];
                r_owner     <= w_grant;
                r_credit    <= w_credit_nxt;
                if (w_credit_nxt == '0) r_ptr <= ptr_inc(w_grant);
                else if (w_lost)        r_ptr <= ptr_inc(r_owner);
            end else if (w_lost) begin
                r_ptr    <= ptr_inc(r_owner);
                r_credit <= '0;
            end
        end
    end

    // Issued-read client ids; storage needs no reset since r_cnt gates its use.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= w_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp            <= '0;
            r_rp            <= '0;
            r_cnt           <= '0;
            r_client_rvalid <= '0;
            r_client_rdata  <= '0;
            r_err           <= 1'b0;
        end else begin
            r_client_rvalid <= '0;
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop) begin
                r_rp                          <= r_rp + PW'(1);
                r_client_rvalid[r_fifo[r_rp]] <= 1'b1;
                r_client_rdata                <= mem_rdata;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (mem_rvalid && r_cnt == '0) r_err <= 1'b1;
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_read      = r_mem_read;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_tag       = r_mem_tag;
    assign client_rvalid = r_client_rvalid;
    assign client_rdata  = r_client_rdata;
    assign err_unexp_rsp = r_err;

endmodule

// File: tb/tb_arb_wrr_n.sv
// Randomized and directed bench for arb_wrr_n against a cycle-level reference model.
module tb_arb_wrr_n;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned TW    = 4;
    localparam int unsigned WW    = 4;
    localparam int unsigned OUTST = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    client_req = '0;
    logic [N-1:0]    client_read = '0;
    logic [N*AW-1:0] client_addr = '0;
    logic [N*W-1:0]  client_wdata = '0;
    logic [N*TW-1:0] client_tag = '0;
    logic [N*WW-1:0] client_weight = '0;
    logic [N-1:0]    client_bsy;
    logic            mem_req;
    logic            mem_bsy = 1'b0;
    logic            mem_read;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [TW-1:0]   mem_tag;
    logic            mem_rvalid = 1'b0;
    logic [W-1:0]    mem_rdata = '0;
    logic [N-1:0]    client_rvalid;
    logic [W-1:0]    client_rdata;
    logic            err_unexp_rsp;

    always #5 clk = ~clk;

    arb_wrr_n #(.N(N), .W(W), .AW(AW), .TW(TW), .WW(WW), .OUTST(OUTST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .client_req    (client_req),
        .client_read   (client_read),
        .client_addr   (client_addr),
        .client_wdata  (client_wdata),
        .client_tag    (client_tag),
        .client_weight (client_weight),
        .client_bsy    (client_bsy),
        .mem_req       (mem_req),
        .mem_bsy       (mem_bsy),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_tag       (mem_tag),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .client_rvalid (client_rvalid),
        .client_rdata  (client_rdata),
        .err_unexp_rsp (err_unexp_rsp)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int            wt [N];
    int            m_ptr, m_owner, m_credit;
    int            q [$];
    bit            m_req, m_rd, m_err;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_wdata;
    logic [TW-1:0] m_tag;
    logic [N-1:0]  m_rv;
    logic [W-1:0]  m_rdata;

    // Observed history taken from the DUT
    int            gnt_log [$];
    int            rsp_id [$];
    logic [W-1:0]  rsp_dat [$];

    task automatic apply_weights();
        for (int i = 0; i < N; i++) client_weight[i*WW +: WW] = WW'(wt[i]);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_credit = 0;
        q.delete();
        m_req = 0; m_rd = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_tag = '0;
        m_rv = '0; m_rdata = '0;
    endtask

    task automatic check_reset_vals();
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_read", 64'(mem_read), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_mem_tag", 64'(mem_tag), 64'(0));
        check("rst_client_rvalid", 64'(client_rvalid), 64'(0));
        check("rst_client_rdata", 64'(client_rdata), 64'(0));
        check("rst_err", 64'(err_unexp_rsp), 64'(0));
        check("rst_client_bsy", 64'(client_bsy), 64'({N{1'b1}}));
    endtask

    // Asserts reset between clock edges, checks the immediate effect, releases on the next negedge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        client_req = '0; client_read = '0; mem_bsy = 1'b0; mem_rvalid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus: drive at negedge, check the grant, advance the model, check after the edge.
    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] rd, input logic mb,
                        input logic rv, input logic [W-1:0] rdat);
        bit load, full, gv, cont;
        int g, prev_owner, prev_credit, id;
        logic [N-1:0] elig, exp_bsy;
        @(negedge clk);
        client_req = rq; client_read = rd; mem_bsy = mb; mem_rvalid = rv; mem_rdata = rdat;
        for (int i = 0; i < N; i++) begin
            client_addr[i*AW +: AW] = AW'($urandom);
            client_wdata[i*W +: W]  = W'($urandom);
            client_tag[i*TW +: TW]  = TW'($urandom);
        end
        #1;
        load = !m_req || !mb;
        full = (q.size() == OUTST);
        for (int i = 0; i < N; i++) elig[i] = rq[i] && !(rd[i] && full);
        gv = 0; g = 0;
        cont = load && m_credit > 0 && elig[m_owner];
        if (cont) begin
            g = m_owner; gv = 1;
        end else if (load) begin
            for (int k = 0; k < N; k++) begin
                if (!gv && elig[(m_ptr + k) % N]) begin g = (m_ptr + k) % N; gv = 1; end
            end
        end
        exp_bsy = '1;
        if (gv) exp_bsy[g] = 1'b0;
        check("client_bsy", 64'(client_bsy), 64'(exp_bsy));
        for (int i = 0; i < N; i++) if (!client_bsy[i]) gnt_log.push_back(i);

        m_rv = '0;
        if (rv) begin
            if (q.size() > 0) begin
                id = q.pop_front();
                m_rv[id] = 1'b1;
                m_rdata = rdat;
            end else begin
                m_err = 1;
            end
        end
        prev_owner = m_owner; prev_credit = m_credit;
        if (load) m_req = gv;
        if (gv) begin
            m_rd = rd[g]; m_addr = client_addr[g*AW +: AW];
            m_wdata = client_wdata[g*W +: W]; m_tag = client_tag[g*TW +: TW];
            if (rd[g]) q.push_back(g);
            if (cont) m_credit = m_credit - 1;
            else begin
                m_owner = g;
                m_credit = ((wt[g] == 0) ? 1 : wt[g]) - 1;
            end
            if (m_credit == 0) m_ptr = (g + 1) % N;
            else if (!cont && prev_credit > 0) m_ptr = (prev_owner + 1) % N;
        end else if (load && m_credit > 0) begin
            m_ptr = (m_owner + 1) % N;
            m_credit = 0;
        end

        @(posedge clk);
        #1;
        check("mem_req", 64'(mem_req), 64'(m_req));
        if (m_req) begin
            check("mem_read", 64'(mem_read), 64'(m_rd));
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            check("mem_tag", 64'(mem_tag), 64'(m_tag));
        end
        check("client_rvalid", 64'(client_rvalid), 64'(m_rv));
        check("client_rdata", 64'(client_rdata), 64'(m_rdata));
        check("err_unexp_rsp", 64'(err_unexp_rsp), 64'(m_err));
        for (int i = 0; i < N; i++) begin
            if (client_rvalid[i]) begin rsp_id.push_back(i); rsp_dat.push_back(client_rdata); end
        end
    endtask

    initial begin
        int base, rbase, sz;
        int pat [7] = '{0, 0, 0, 1, 2, 2, 3};
        logic [AW-1:0] saved_addr;
        logic [W-1:0] dat [3] = '{16'h000A, 16'h000B, 16'h000C};
        int ord [3] = '{0, 2, 1};

        // Plain round-robin, weights 1
        for (int i = 0; i < N; i++) wt[i] = 1;
        apply_weights();
        client_req = '1;
        do_reset();
        base = gnt_log.size();
        repeat (8) step('1, '0, 1'b0, 1'b0, '0);
        check("rr_count", 64'(gnt_log.size() - base), 64'(8));
        for (int i = 0; i < 8 && base + i < gnt_log.size(); i++)
            check("rr_order", 64'(gnt_log[base + i]), 64'(i % 4));

        // Weighted bursts {3,1,2,1}
        wt = '{3, 1, 2, 1};
        apply_weights();
        do_reset();
        base = gnt_log.size();
        repeat (14) step('1, '0, 1'b0, 1'b0, '0);
        check("wrr_count", 64'(gnt_log.size() - base), 64'(14));
        for (int i = 0; i < 14 && base + i < gnt_log.size(); i++)
            check("wrr_order", 64'(gnt_log[base + i]), 64'(pat[i % 7]));

        // Memory back-pressure holds the slot
        for (int i = 0; i < N; i++) wt[i] = 1;
        apply_weights();
        do_reset();
        step(4'b0100, '0, 1'b0, 1'b0, '0);
        saved_addr = client_addr[2*AW +: AW];
        sz = gnt_log.size();
        for (int c = 0; c < 5; c++) begin
            step('1, '0, 1'b1, 1'b0, '0);
            check("stall_addr", 64'(mem_addr), 64'(saved_addr));
        end
        check("stall_nogrant", 64'(gnt_log.size()), 64'(sz));
        step('1, '0, 1'b0, 1'b0, '0);
        check("stall_release", 64'(gnt_log.size()), 64'(sz + 1));
        if (gnt_log.size() > 0) check("stall_release_id", 64'(gnt_log[$]), 64'(3));

        // Outstanding limit blocks reads, not writes
        do_reset();
        repeat (OUTST) step(4'b0001, 4'b0001, 1'b0, 1'b0, '0);
        base = gnt_log.size();
        repeat (3) step(4'b1010, 4'b0010, 1'b0, 1'b0, '0);
        check("full_write_cnt", 64'(gnt_log.size() - base), 64'(3));
        for (int i = base; i < gnt_log.size(); i++) check("full_write_id", 64'(gnt_log[i]), 64'(3));
        step(4'b1010, 4'b0010, 1'b0, 1'b1, 16'h0055);
        step(4'b1010, 4'b0010, 1'b0, 1'b0, '0);
        if (gnt_log.size() > 0) check("full_read_accept", 64'(gnt_log[$]), 64'(1));
        repeat (OUTST) step('0, '0, 1'b0, 1'b1, W'($urandom));

        // In-order response routing
        step(4'b0001, 4'b0001, 1'b0, 1'b0, '0);
        step(4'b0100, 4'b0100, 1'b0, 1'b0, '0);
        step(4'b0010, 4'b0010, 1'b0, 1'b0, '0);
        rbase = rsp_id.size();
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1, dat[i]);
        check("rsp_count", 64'(rsp_id.size() - rbase), 64'(3));
        for (int i = 0; i < 3 && rbase + i < rsp_id.size(); i++) begin
            check("rsp_id", 64'(rsp_id[rbase + i]), 64'(ord[i]));
            check("rsp_data", 64'(rsp_dat[rbase + i]), 64'(dat[i]));
        end

        // Unexpected response is sticky
        step('0, '0, 1'b0, 1'b1, 16'h0077);
        check("err_set", 64'(err_unexp_rsp), 64'(1));
        repeat (5) step('0, '0, 1'b0, 1'b0, '0);
        check("err_sticky", 64'(err_unexp_rsp), 64'(1));

        // Random traffic with random weights (0 behaves as 1)
        for (int i = 0; i < N; i++) wt[i] = $urandom_range(0, 3);
        apply_weights();
        do_reset();
        repeat (600) step(N'($urandom), N'($urandom), ($urandom % 3) == 0,
                          ($urandom % 4) == 0, W'($urandom));

        // Reset in the middle of a burst
        repeat (4) step('1, '1, 1'b1, 1'b0, '0);
        do_reset();
        step('1, '0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
